// File: rtl/dot_stream_mac.sv
// Streaming signed dot-product MAC: N element pairs in, one wrapped sum out; result 1 cycle after last accept.
// Result is held while out_ready=0; in_ready stays low until the cycle after the output handshake.
module dot_stream_mac #(
   parameter int N     = 2,
   parameter int W     = 8,
   parameter int ACC_W = 32,
   parameter int O_W   = 8,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [W-1:0]     arg_0,
   input  logic signed [W-1:0]     arg_1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [O_W-1:0]          out_0,
   output logic [ACC_W-1:0]        out_acc,
   output logic [IDX_W-1:0]        idx
);

   typedef enum logic {
      ST_ACCUM  = 1'b0,
      ST_OUTPUT = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   state_t               state_q, state_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic signed [2*W-1:0] prod;
   logic [ACC_W-1:0]     prod_ext;

   assign prod     = arg_0 * arg_1;
   assign prod_ext = ACC_W'(prod);

   // Handshake flags are gated by rst so nothing is advertised while reset is held.
   assign in_ready  = (state_q == ST_ACCUM)  && !rst;
   assign out_valid = (state_q == ST_OUTPUT) && !rst;
   assign out_acc   = acc_q;
   assign out_0     = acc_q[O_W-1:0];
   assign idx       = idx_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               acc_d = acc_q + prod_ext;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_OUTPUT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_OUTPUT: begin
            if (out_ready) begin
               acc_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_dot_stream_mac.sv
// Directed bench for dot_stream_mac (N=2, W=8, ACC_W=32, O_W=8); inputs change and outputs are sampled on the falling edge.
module tb_dot_stream_mac;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  arg_0;
   logic [7:0]  arg_1;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_0;
   logic [31:0] out_acc;
   logic [0:0]  idx;

   int n_chk  = 0;
   int n_fail = 0;

   dot_stream_mac #(.N(2), .W(8), .ACC_W(32), .O_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .arg_0     (arg_0),
      .arg_1     (arg_1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_0     (out_0),
      .out_acc   (out_acc),
      .idx       (idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input, then advance to the next falling edge.
   task automatic drive(input logic iv, input int a, input int b);
      logic [31:0] av, bv;
      av = a;
      bv = b;
      in_valid = iv;
      arg_0    = av[7:0];
      arg_1    = bv[7:0];
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      arg_0     = '0;
      arg_1     = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready",  in_ready,  0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc",   out_acc,   0);
      chk("rst_out_0",     out_0,     0);
      chk("rst_idx",       idx,       0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Basic: 3*4 + (-2)*5 = 2
      out_ready = 1'b1;
      drive(1, 3, 4);
      chk("basic_idx1",     idx,     1);
      chk("basic_partial",  out_acc, 32'd12);
      drive(1, -2, 5);
      chk("basic_out_valid", out_valid, 1);
      chk("basic_in_ready",  in_ready,  0);
      chk("basic_out_acc",   out_acc,   32'h0000_0002);
      chk("basic_out_0",     out_0,     8'h02);
      chk("basic_idx0",      idx,       0);
      drive(0, 0, 0);
      chk("basic_ret_in_ready",  in_ready,  1);
      chk("basic_ret_out_valid", out_valid, 0);
      chk("basic_ret_acc",       out_acc,   0);

      // Truncation: 2 * 16384 = 0x8000, low byte 0
      drive(1, -128, -128);
      drive(1, -128, -128);
      chk("trunc_out_valid", out_valid, 1);
      chk("trunc_out_acc",   out_acc,   32'h0000_8000);
      chk("trunc_out_0",     out_0,     8'h00);
      drive(0, 0, 0);

      // Negative result with 5 cycles of backpressure and in_valid held high
      out_ready = 1'b0;
      drive(1, -1, 1);
      chk("neg_partial", out_acc, 32'hFFFF_FFFF);
      drive(1, 0, 7);
      chk("neg_out_valid", out_valid, 1);
      chk("neg_out_acc",   out_acc,   32'hFFFF_FFFF);
      chk("neg_out_0",     out_0,     8'hFF);
      for (int i = 0; i < 5; i++) begin
         drive(1, 9, 9);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready",  in_ready,  0);
         chk("bp_out_acc",   out_acc,   32'hFFFF_FFFF);
         chk("bp_out_0",     out_0,     8'hFF);
         chk("bp_idx",       idx,       0);
      end
      out_ready = 1'b1;
      drive(0, 0, 0);
      chk("bp_rel_in_ready",  in_ready,  1);
      chk("bp_rel_out_valid", out_valid, 0);
      chk("bp_rel_acc",       out_acc,   0);
      chk("bp_rel_idx",       idx,       0);

      // Gaps: 2*3 + 4*5 = 26 with in_valid 1,0,0,1
      drive(1, 2, 3);
      chk("gap_idx_a", idx, 1);
      drive(0, 7, 7);
      chk("gap_idx_b", idx, 1);
      chk("gap_acc_b", out_acc, 32'd6);
      drive(0, 7, 7);
      chk("gap_idx_c", idx, 1);
      drive(1, 4, 5);
      chk("gap_idx_d",     idx,       0);
      chk("gap_out_valid", out_valid, 1);
      chk("gap_out_acc",   out_acc,   32'h0000_001A);
      chk("gap_out_0",     out_0,     8'h1A);
      drive(0, 0, 0);

      // Reset mid-vector discards the 25 partial sum
      drive(1, 5, 5);
      chk("rmv_partial", out_acc, 32'd25);
      rst = 1'b1;
      drive(0, 0, 0);
      chk("rmv_acc_cleared", out_acc,  0);
      chk("rmv_idx_cleared", idx,      0);
      chk("rmv_in_ready",    in_ready, 0);
      rst = 1'b0;
      #1;
      chk("rmv_in_ready_up", in_ready, 1);
      drive(1, 1, 1);
      chk("rmv_partial2", out_acc, 32'd1);
      drive(1, 2, 2);
      chk("rmv_out_valid", out_valid, 1);
      chk("rmv_out_acc",   out_acc,   32'h0000_0005);
      chk("rmv_out_0",     out_0,     8'h05);
      drive(0, 0, 0);

      // Reset during OUTPUT wins over a simultaneous handshake
      out_ready = 1'b0;
      drive(1, 1, 2);
      drive(1, 3, 4);
      chk("rout_out_acc", out_acc, 32'd14);
      rst       = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rout_out_valid_rst", out_valid, 0);
      drive(0, 0, 0);
      rst = 1'b0;
      #1;
      chk("rout_out_valid_after", out_valid, 0);
      chk("rout_acc_after",       out_acc,   0);
      chk("rout_in_ready_after",  in_ready,  1);
      drive(0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dot_stream_mac.md
DOT_STREAM_MAC -- requirements
Module: dot_stream_mac

Interface
REQ-001 SHALL have parameter N, default 2: number of element pairs per vector (N >= 1).
REQ-002 SHALL have parameter W, default 8: signed width of each input element.
REQ-003 SHALL have parameter ACC_W, default 32: accumulator width (ACC_W >= 2*W).
REQ-004 SHALL have parameter O_W, default 8: output width (O_W <= ACC_W).
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: element pair on arg_0/arg_1 is valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts an element pair this cycle.
REQ-009 SHALL have port arg_0, input, W: signed element a[k].
REQ-010 SHALL have port arg_1, input, W: signed element b[k].
REQ-011 SHALL have port out_valid, output, 1: result on out_0/out_acc is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_0, output, O_W: signed result, sum bits [O_W-1:0].
REQ-014 SHALL have port out_acc, output, ACC_W: full signed accumulated sum.
REQ-015 SHALL have port idx, output, clog2(N) (min 1): index of the next element pair to be accepted.

Function
REQ-016 SHALL implement two states: ACCUM (collecting pairs) and OUTPUT (holding a result).
REQ-017 SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in OUTPUT; the two are never high together.
REQ-018 SHALL accept a pair only when in_valid && in_ready; a cycle with in_valid=0 changes nothing (gaps allowed).
REQ-019 SHALL form each product as the full 2*W-bit signed product of arg_0 and arg_1.
REQ-020 SHALL sign-extend that product to ACC_W bits and add it to the accumulator on each accept.
REQ-021 SHALL wrap the accumulator modulo 2^ACC_W, with no saturation.
REQ-022 SHALL increment idx on each accept.
REQ-023 On the accept with idx==N-1, SHALL set idx to 0 and move to OUTPUT in the next cycle.
REQ-024 SHALL make the result (including the last product) visible on out_acc/out_0 in the cycle after the last accept: latency 1 cycle.
REQ-025 SHALL set out_0 = out_acc[O_W-1:0], truncated, not saturated.
REQ-026 SHALL hold out_valid, out_0 and out_acc stable in OUTPUT while out_ready=0 (backpressure, any duration).
REQ-027 When out_valid && out_ready, SHALL clear the accumulator to 0 and return to ACCUM.
REQ-028 After an output handshake, in_ready SHALL rise in the next cycle, with no same-cycle bypass.
REQ-029 Minimum period between results SHALL be N+1 cycles.
REQ-030 in_valid asserted during OUTPUT SHALL be ignored; the pair is not consumed.
REQ-031 In ACCUM, out_0 and out_acc SHALL show the running partial sum.
REQ-032 SHALL use no combinational path from in_valid to in_ready, nor from out_ready to out_valid.

Reset
REQ-033 When rst=1 at a clock edge, SHALL enter ACCUM with accumulator=0, idx=0, out_valid=0, out_0=0, out_acc=0.
REQ-034 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-035 Reset mid-vector or during OUTPUT SHALL discard the partial sum or pending result; no result is emitted for it.
REQ-036 rst SHALL take priority over any simultaneous handshake in the same cycle.

Verification
REQ-037 Bench SHALL cover basic operation (N=2,W=8): pairs (3,4) then (-2,5), out_ready=1 -> out_valid one cycle after 2nd accept; out_acc=0x00000002; out_0=0x02.
REQ-038 Bench SHALL cover truncation: pairs (-128,-128),(-128,-128) -> out_acc=0x00008000; out_0=0x00.
REQ-039 Bench SHALL cover negative result: pairs (-1,1),(0,7) -> out_acc=0xFFFFFFFF; out_0=0xFF.
REQ-040 Bench SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 throughout -> out_valid and values held, in_ready=0, no pair consumed; out_ready=1 -> next cycle in_ready=1, accumulator 0.
REQ-041 Bench SHALL cover input gaps: in_valid toggled 1,0,0,1 -> idx steps 0->1->1->1->0 and a correct single result.
REQ-042 Bench SHALL cover reset mid-vector: after the 1st accept (5,5), assert rst one cycle, then send (1,1),(2,2) -> result 0x00000005; value 25 never appears.
